dadda_pipe: RTL

Parametrised, pipelined Dadda-tree unsigned multiplier with a valid/ready streaming handshake and a run-time selectable approximate mode. It is the clocked, width-generic successor to the fixed 6-bit combinational Dadda multipliers in the approximate-multiplier library. It is the unit instantiated inside datapaths that need throughput of one product per cycle under backpressure. In approximate mode, the low product columns are reduced with OR-compression to cut carry logic. This trades a bounded low-order error for area and power.

---
 rtl/dadda_pipe_if.sv | 25 ++
 rtl/dadda_pipe.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dadda_pipe_if.sv
// Streaming handshake bundle for dadda_pipe: operand side (in_*) and result side (out_*).
// The slave modport is the multiplier; the master modport is whoever drives and drains it.
interface dadda_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             approx_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] overflow;

    modport master (
        output in_valid, in1, in2, approx_en, out_ready,
        input  in_ready, out_valid, out, overflow
    );

    modport slave (
        input  in_valid, in1, in2, approx_en, out_ready,
        output in_ready, out_valid, out, overflow
    );
endinterface

// File: rtl/dadda_pipe.sv
// Pipelined unsigned Dadda-tree multiplier with valid/ready streaming and a per-transaction
// approximate mode that OR-compresses the low APPROX_COLS product columns.
module dadda_pipe #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned STAGES      = 2,
    parameter int unsigned APPROX_COLS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    dadda_pipe_if.slave bus
);
    localparam int W  = int'(WIDTH);
    localparam int PW = 2 * W;
    localparam logic [PW-1:0] One     = {{(PW - 1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] LowMask = (One << APPROX_COLS) - One;

    // Partial products of column col are stacked by multiplicand index starting at col_lo.
    function automatic int col_lo(input int col);
        return (col >= W) ? col - W + 1 : 0;
    endfunction

    function automatic int col_height(input int col);
        int hi;
        hi = (col < W) ? col : W - 1;
        return (hi >= col_lo(col)) ? hi - col_lo(col) + 1 : 0;
    endfunction

    // Dadda reduction down to two rows; returns {row1, row0}.
    function automatic logic [2*PW-1:0] dadda_reduce(input logic [PW-1:0][W-1:0] mat);
        logic [PW-1:0][W-1:0] cur;
        logic [PW-1:0][W-1:0] nxt;
        logic [PW-1:0]        row0;
        logic [PW-1:0]        row1;
        int                   h_cur   [PW];
        int                   h_nxt   [PW];
        int                   targets [16];
        int                   n_t;
        int                   d;
        int                   idx;
        int                   left;
        logic                 s;
        logic                 c;

        cur = mat;
        for (int col = 0; col < PW; col++) h_cur[col] = col_height(col);
        for (int k = 0; k < 16; k++) targets[k] = 0;
        targets[0] = 2;
        n_t = 1;
        for (int k = 1; k < 16; k++) begin
            if (n_t == k && (targets[k-1] * 3) / 2 < W) begin
                targets[k] = (targets[k-1] * 3) / 2;
                n_t = k + 1;
            end
        end

        for (int t = 15; t >= 0; t--) begin
            if (t < n_t) begin
                d   = targets[t];
                nxt = '0;
                for (int col = 0; col < PW; col++) h_nxt[col] = 0;
                for (int col = 0; col < PW; col++) begin
                    idx = 0;
                    for (int k = 0; k < W; k++) begin
                        left = h_cur[col] - idx;
                        if (left + h_nxt[col] > d && left >= 2) begin
                            if (left + h_nxt[col] - d >= 2 && left >= 3) begin
                                s = cur[col][idx] ^ cur[col][idx+1] ^ cur[col][idx+2];
                                c = (cur[col][idx] & cur[col][idx+1]) |
                                    (cur[col][idx+2] & (cur[col][idx] ^ cur[col][idx+1]));
                                idx = idx + 3;
                            end else begin
                                s   = cur[col][idx] ^ cur[col][idx+1];
                                c   = cur[col][idx] & cur[col][idx+1];
                                idx = idx + 2;
                            end
                            nxt[col][h_nxt[col]] = s;
                            h_nxt[col] = h_nxt[col] + 1;
                            if (col + 1 < PW) begin
                                nxt[col+1][h_nxt[col+1]] = c;
                                h_nxt[col+1] = h_nxt[col+1] + 1;
                            end
                        end
                    end
                    for (int k = 0; k < W; k++) begin
                        if (k >= idx && k < h_cur[col]) begin
                            nxt[col][h_nxt[col]] = cur[col][k];
                            h_nxt[col] = h_nxt[col] + 1;
                        end
                    end
                end
                cur   = nxt;
                h_cur = h_nxt;
            end
        end

        for (int col = 0; col < PW; col++) begin
            row0[col] = cur[col][0];
            row1[col] = cur[col][1];
        end
        return {row1, row0};
    endfunction

    logic [PW-1:0][W-1:0] pp_mat;
    logic [PW-1:0]        or_bits;
    logic [2*PW-1:0]      rows;
    logic [PW-1:0]        row_a;
    logic [PW-1:0]        row_b;

    // Approximated columns are kept out of the tree entirely, so they can never carry upward.
    always_comb begin
        pp_mat  = '0;
        or_bits = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                if (bus.approx_en && LowMask[i+j]) begin
                    or_bits[i+j] = or_bits[i+j] | (bus.in1[i] & bus.in2[j]);
                end else begin
                    pp_mat[i+j][i - col_lo(i + j)] = bus.in1[i] & bus.in2[j];
                end
            end
        end
        rows  = dadda_reduce(pp_mat);
        row_a = rows[PW-1:0] | or_bits;
        row_b = rows[2*PW-1:PW];
    end

    logic [STAGES-1:0] valid_q;
    logic [PW-1:0]     prod_d;
    logic [PW-1:0]     prod_q;
    logic              last_in_valid;
    logic              advance;

    // Global stall: every stage moves only when the output slot is free or draining.
    assign advance       = !(valid_q[STAGES-1] && !bus.out_ready);
    assign bus.in_ready  = advance;
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.out       = prod_q[W-1:0];
    assign bus.overflow  = prod_q[PW-1:W];

    if (STAGES == 1) begin : g_single
        assign prod_d        = row_a + row_b;
        assign last_in_valid = bus.in_valid;
    end else begin : g_multi
        logic [PW-1:0] a_q [STAGES-1];
        logic [PW-1:0] b_q [STAGES-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < STAGES - 1; k++) begin
                    a_q[k] <= '0;
                    b_q[k] <= '0;
                end
            end else if (advance) begin
                if (bus.in_valid) begin
                    a_q[0] <= row_a;
                    b_q[0] <= row_b;
                end
                for (int k = 1; k < STAGES - 1; k++) begin
                    if (valid_q[k-1]) begin
                        a_q[k] <= a_q[k-1];
                        b_q[k] <= b_q[k-1];
                    end
                end
            end
        end

        assign prod_d        = a_q[STAGES-2] + b_q[STAGES-2];
        assign last_in_valid = valid_q[STAGES-2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            prod_q  <= '0;
        end else if (advance) begin
            valid_q[0] <= bus.in_valid;
            for (int k = 1; k < STAGES; k++) valid_q[k] <= valid_q[k-1];
            if (last_in_valid) prod_q <= prod_d;
        end
    end
endmodule
